fpu_norm_round_pipe: RTL and testbench
======================================

// Module: fpu_norm_round_pipe
// PURPOSE
// Parametrised, pipelined normaliser/rounder for the div/sqrt datapath and sibling units.
// - Input: raw result (sign, signed biased exponent, mantissa with guard/round bits, sticky)
//   plus an operand-class code.
// - Output: IEEE-754 packed result and the five exception flags.
// - Runs behind a valid/ready handshake with a pass-through tag.
// - Adds over the previous normaliser: generic EXP_W/MANT_W, RMM mode, an NX flag,
//   max-finite overflow saturation, and pipelining.
// PARAMETERS
// EXP_W    8   exponent field width
// MANT_W   23  stored fraction width
// TAG_W    4   width of the opaque tag carried alongside each operation
// STAGES   2   pipeline register stages (1 or 2); latency = STAGES cycles
// PORTS
// Clk_CI       in   1            clock
// Rst_RI       in   1            asynchronous reset, active-high
// In_valid_SI  in   1            input operation valid
// In_ready_SO  out  1            unit can accept an operation this cycle
// Mant_in_DI   in   MANT_W+3     [MANT_W+2] integer bit, [MANT_W+1:2] fraction, [1] guard, [0] round
// Sticky_in_SI in   1            OR of all lower discarded bits from upstream
// Exp_in_DI    in   EXP_W+2      signed biased exponent
// Sign_in_DI   in   1            result sign
// Class_in_DI  in   3            0 normal, 1 zero, 2 inf, 3 invalid(NaN), 4 div-by-zero
// RM_in_DI     in   3            000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others = RNE
// Tag_in_DI    in   TAG_W        opaque tag
// Out_valid_SO out  1            result valid
// Out_ready_SI in   1            consumer accepts the result
// Result_DO    out  EXP_W+MANT_W+1  {sign, exp, frac}
// Flags_DO     out  5            {NV, DZ, OF, UF, NX}
// Tag_DO       out  TAG_W        tag of the current result
// BEHAVIOUR
// - Reset values: Out_valid_SO=0, Result_DO=0, Flags_DO=0, Tag_DO=0; In_ready_SO=1 after reset.
// - Reset mid-operation discards every in-flight operation; no result emerges for it.
// - Handshake:
//   - Per-stage enable en_i = ~valid_i | en_(i+1); last-stage enable = ~Out_valid_SO | Out_ready_SI.
//   - In_ready_SO = stage-0 enable.
//   - Throughput is 1 op/cycle with no bubbles under continuous ready.
//   - Results leave in issue order; outputs hold stable while Out_valid_SO & ~Out_ready_SI.
// - Stage A, normalise:
//   - Integer bit = 0: shift left 1, exp-1. The input is guaranteed to lie in [0.5, 2).
//   - If exp <= 0: right-shift by 1-exp. Shifts >= MANT_W+3 move everything into sticky.
//     Then exp = 0 and the result is flagged tiny.
// - Stage B, round:
//   - guard = first discarded bit; sticky = OR of the remaining bits and Sticky_in_SI.
//   - RNE: g & (s | lsb). RTZ: never. RDN: (g|s) & sign. RUP: (g|s) & ~sign. RMM: g.
//   - Mantissa carry-out renormalises: frac = 0, exp+1. A subnormal that rounds into 1.0 becomes exp = 1.
// - Overflow (exp >= 2^EXP_W-1 after rounding): OF and NX are set.
//   - RNE, RMM, and the directed mode toward the sign give inf.
//   - RTZ and the directed mode away from the sign give max finite (exp = all-ones-1, frac = all ones).
// - NX = guard | sticky, or overflow.
// - UF = tiny (before rounding) & NX.
// - Special classes bypass rounding: Flags = 0 except as listed.
//   - zero: signed zero.
//   - inf: signed inf.
//   - invalid: canonical qNaN {0, all ones, 1 then zeros}, NV.
//   - div-by-zero: signed inf, DZ.
// - STAGES=1 merges A and B into one register stage. Any other STAGES value is an elaboration error.
// CONFIGURATION
// FPU_NORM_DENORM_EN
// - Defined: tiny results are produced as rounded subnormals as described above.
// - Undefined: tiny results flush to signed zero with UF|NX set and no right shift.
//   This removes the denormal shifter.
// TESTING (EXP_W=8, MANT_W=23, STAGES=2)
// 1) Mant=1.0, Exp=127, RNE -> 0x3F800000, Flags=0, Out_valid exactly 2 cycles after accept.
// 2) Mant=all ones incl. guard, Exp=127, RNE -> 0x40000000 (carry renorm), Flags=NX.
// 3) Mant=1.0, Exp=255: RNE -> 0x7F800000; RTZ -> 0x7F7FFFFF; both Flags=OF|NX.
// 4) Mant=1.0, Exp=-2, RNE:
//    - FPU_NORM_DENORM_EN defined -> 0x00100000, Flags=0.
//    - Undefined -> 0x00000000, Flags=UF|NX.
// 5) Issue tags 0..3 back-to-back with Out_ready_SI low for 5 cycles:
//    - In_ready_SO drops once 2 ops are held and deasserts for the remainder of the stall.
//    - Tags 0..3 then emerge in order, none lost or duplicated.
// 6) Class=3 -> 0x7FC00000, Flags=NV; Class=4 with sign=1 -> 0xFF800000, Flags=DZ.
//    Assert Rst_RI mid-stream -> Out_valid_SO=0 on the next edge.

Source files
------------

// File: rtl/fpu_norm_round_pipe.sv
// fpu_norm_round_pipe: pipelined normalise/round to IEEE-754 with exception flags; define FPU_NORM_DENORM_EN for subnormal outputs (otherwise tiny results flush to zero)
module fpu_norm_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     In_valid_SI,
  output logic                     In_ready_SO,
  input  logic [MANT_W+2:0]        Mant_in_DI,
  input  logic                     Sticky_in_SI,
  input  logic [EXP_W+1:0]         Exp_in_DI,
  input  logic                     Sign_in_DI,
  input  logic [2:0]               Class_in_DI,
  input  logic [2:0]               RM_in_DI,
  input  logic [TAG_W-1:0]         Tag_in_DI,
  output logic                     Out_valid_SO,
  input  logic                     Out_ready_SI,
  output logic [EXP_W+MANT_W:0]    Result_DO,
  output logic [4:0]               Flags_DO,
  output logic [TAG_W-1:0]         Tag_DO
);
  localparam int M = MANT_W + 3;
  localparam int E = EXP_W + 2;
  localparam int W = EXP_W + MANT_W + 1;
  localparam logic [EXP_W-1:0] ONES = '1;
  typedef struct packed {
    logic             sign;
    logic [E-1:0]     exp;
    logic [M-1:0]     mant;
    logic             sticky;
    logic             tiny;
    logic [2:0]       cls;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } a_t;
  typedef struct packed {
    logic [W-1:0]     res;
    logic [4:0]       flg;
    logic [TAG_W-1:0] tag;
  } o_t;
  a_t na, b;
  o_t ob, o_d, o_q;
  logic b_valid, en_o, vo_d, vo_q;
  logic [M-1:0] n_mant;
  logic [E-1:0] n_exp;
  logic tiny;
`ifdef FPU_NORM_DENORM_EN
  logic [E-1:0] sh;
  logic [2*M-1:0] ext;
`endif
  always_comb begin
    n_mant = Mant_in_DI[M-1] ? Mant_in_DI : Mant_in_DI << 1;
    n_exp = Exp_in_DI - E'(!Mant_in_DI[M-1]);
    tiny = n_exp[E-1] | ~|n_exp;
    na = '0;
    na.sign = Sign_in_DI;
    na.exp = tiny ? '0 : n_exp;
    na.tiny = tiny;
    na.cls = Class_in_DI;
    na.rm = RM_in_DI;
    na.tag = Tag_in_DI;
`ifdef FPU_NORM_DENORM_EN
    sh = E'(1) - n_exp;
    sh = (sh > E'(M)) ? E'(M) : sh;
    ext = {n_mant, {M{1'b0}}} >> sh;
    na.mant = tiny ? ext[2*M-1:M] : n_mant;
    na.sticky = Sticky_in_SI | (tiny & |ext[M-1:0]);
`else
    na.mant = n_mant;
    na.sticky = Sticky_in_SI;
`endif
  end
  logic g, s, inc, carry, ovf, nx, to_inf;
  logic [MANT_W+1:0] sum;
  logic [E-1:0] r_exp;
  always_comb begin
    g = b.mant[1];
    s = b.mant[0] | b.sticky;
    inc = b.rm == 3'd1 ? 1'b0 :
          b.rm == 3'd2 ? (g | s) & b.sign :
          b.rm == 3'd3 ? (g | s) & ~b.sign :
          b.rm == 3'd4 ? g : g & (s | b.mant[2]);
    sum = {1'b0, b.mant[M-1:2]} + (MANT_W+2)'(inc);
    carry = sum[MANT_W+1];
    r_exp = carry ? b.exp + E'(1) : (~|b.exp & sum[MANT_W]) ? E'(1) : b.exp;
    ovf = r_exp >= E'((1 << EXP_W) - 1);
    nx = g | s | ovf;
    to_inf = b.rm == 3'd1 ? 1'b0 : b.rm == 3'd2 ? b.sign : b.rm == 3'd3 ? ~b.sign : 1'b1;
    ob.tag = b.tag;
    ob.flg = {2'b00, ovf, b.tiny & nx, nx};
    ob.res = ovf ? (to_inf ? {b.sign, ONES, {MANT_W{1'b0}}} : {b.sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MANT_W{1'b1}}})
                 : {b.sign, r_exp[EXP_W-1:0], carry ? {MANT_W{1'b0}} : sum[MANT_W-1:0]};
`ifndef FPU_NORM_DENORM_EN
    if (b.tiny) begin
      ob.res = {b.sign, {(W-1){1'b0}}};
      ob.flg = 5'b00011;
    end
`endif
    if (b.cls == 3'd1) begin
      ob.res = {b.sign, {(W-1){1'b0}}};
      ob.flg = '0;
    end else if (b.cls == 3'd2 || b.cls == 3'd4) begin
      ob.res = {b.sign, ONES, {MANT_W{1'b0}}};
      ob.flg = {1'b0, b.cls == 3'd4, 3'b000};
    end else if (b.cls == 3'd3) begin
      ob.res = {1'b0, ONES, 1'b1, {(MANT_W-1){1'b0}}};
      ob.flg = 5'b10000;
    end
  end
  // Output data only reloads on a real transfer so it holds stable under backpressure
  always_comb begin
    en_o = ~vo_q | Out_ready_SI;
    vo_d = en_o ? b_valid : vo_q;
    o_d = (en_o & b_valid) ? ob : o_q;
  end
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      vo_q <= 1'b0;
      o_q <= '0;
    end else begin
      vo_q <= vo_d;
      o_q <= o_d;
    end
  end
  if (STAGES == 2) begin : g_two
    a_t a_d, a_q;
    logic en_a, va_d, va_q;
    always_comb begin
      en_a = ~va_q | en_o;
      va_d = en_a ? In_valid_SI : va_q;
      a_d = (en_a & In_valid_SI) ? na : a_q;
    end
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
        va_q <= 1'b0;
        a_q <= '0;
      end else begin
        va_q <= va_d;
        a_q <= a_d;
      end
    end
    assign b = a_q;
    assign b_valid = va_q;
    assign In_ready_SO = en_a;
  end else if (STAGES == 1) begin : g_one
    assign b = na;
    assign b_valid = In_valid_SI;
    assign In_ready_SO = en_o;
  end else begin : g_bad
    $error("fpu_norm_round_pipe: STAGES must be 1 or 2");
  end
  assign Out_valid_SO = vo_q;
  assign Result_DO = o_q.res;
  assign Flags_DO = o_q.flg;
  assign Tag_DO = o_q.tag;
endmodule

// File: tb/tb_fpu_norm_round_pipe.sv
// tb_fpu_norm_round_pipe: directed scoreboard bench for fpu_norm_round_pipe at EXP_W=8, MANT_W=23, STAGES=2
module tb_fpu_norm_round_pipe;
  localparam logic [25:0] ONE = 26'h2000000;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sticky = 1'b0, sign = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [25:0] mant = '0;
  logic [9:0] expn = '0;
  logic [2:0] cls = '0, rm = '0;
  logic [3:0] tag_i = '0, tag_o;
  logic [31:0] res;
  logic [4:0] flg;
  typedef struct packed {
    logic [3:0]  t;
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fpu_norm_round_pipe dut (
    .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(in_valid), .In_ready_SO(in_ready),
    .Mant_in_DI(mant), .Sticky_in_SI(sticky), .Exp_in_DI(expn), .Sign_in_DI(sign),
    .Class_in_DI(cls), .RM_in_DI(rm), .Tag_in_DI(tag_i), .Out_valid_SO(out_valid),
    .Out_ready_SI(out_ready), .Result_DO(res), .Flags_DO(flg), .Tag_DO(tag_o)
  );
  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, x);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output_tag", {28'd0, tag_o}, 32'hFFFFFFFF);
      else begin
        e = sb.pop_front();
        chk("out_tag", {28'd0, tag_o}, {28'd0, e.t});
        chk("out_result", res, e.r);
        chk("out_flags", {27'd0, flg}, {27'd0, e.f});
      end
    end
  end
  task automatic send(input logic [25:0] m, input logic [9:0] x, input logic sg, input logic st,
                      input logic [2:0] c, input logic [2:0] r, input logic [3:0] t,
                      input logic [31:0] er, input logic [4:0] ef);
    int n = 0;
    sb.push_back({t, er, ef});
    in_valid = 1'b1; mant = m; expn = x; sign = sg; sticky = st; cls = c; rm = r; tag_i = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_result", res, 0);
    chk("rst_flags", {27'd0, flg}, 0);
    chk("rst_tag", {28'd0, tag_o}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    // latency: accepted at the first edge, visible after the second
    sb.push_back({4'd1, 32'h3F800000, 5'd0});
    in_valid = 1'b1; mant = ONE; expn = 10'd127; sign = 1'b0; sticky = 1'b0; cls = 3'd0; rm = 3'd0; tag_i = 4'd1;
    @(negedge clk);
    chk("lat_ready", {31'd0, in_ready}, 1);
    chk("lat_c0", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_c2", {31'd0, out_valid}, 1);
    drain();
    send(26'h3FFFFFF, 10'd127, 0, 0, 3'd0, 3'd0, 4'd2, 32'h40000000, 5'b00001);
    send(ONE, 10'd255, 0, 0, 3'd0, 3'd0, 4'd3, 32'h7F800000, 5'b00101);
    send(ONE, 10'd255, 0, 0, 3'd0, 3'd1, 4'd4, 32'h7F7FFFFF, 5'b00101);
    send(ONE, 10'd255, 0, 0, 3'd0, 3'd2, 4'd5, 32'h7F7FFFFF, 5'b00101);
    send(ONE, 10'd255, 1, 0, 3'd0, 3'd3, 4'd6, 32'hFF7FFFFF, 5'b00101);
    send(ONE, 10'd255, 1, 0, 3'd0, 3'd2, 4'd7, 32'hFF800000, 5'b00101);
    send(26'h3FFFFFF, 10'd254, 0, 0, 3'd0, 3'd0, 4'd8, 32'h7F800000, 5'b00101);
    send(ONE, 10'd254, 0, 0, 3'd0, 3'd0, 4'd9, 32'h7F000000, 5'b00000);
    send(26'h1000000, 10'd128, 0, 0, 3'd0, 3'd0, 4'd10, 32'h3F800000, 5'b00000);
    send(26'h2000002, 10'd127, 0, 0, 3'd0, 3'd0, 4'd11, 32'h3F800000, 5'b00001);
    send(26'h2000002, 10'd127, 0, 0, 3'd0, 3'd4, 4'd12, 32'h3F800001, 5'b00001);
    send(26'h2000002, 10'd127, 0, 0, 3'd0, 3'd3, 4'd13, 32'h3F800001, 5'b00001);
    send(26'h2000002, 10'd127, 1, 0, 3'd0, 3'd2, 4'd14, 32'hBF800001, 5'b00001);
    send(26'h2000006, 10'd127, 0, 0, 3'd0, 3'd0, 4'd15, 32'h3F800002, 5'b00001);
    send(ONE, 10'd127, 0, 1, 3'd0, 3'd3, 4'd0, 32'h3F800001, 5'b00001);
    send(26'h2000003, 10'd127, 0, 0, 3'd0, 3'd1, 4'd1, 32'h3F800000, 5'b00001);
`ifdef FPU_NORM_DENORM_EN
    send(ONE, 10'h3FE, 0, 0, 3'd0, 3'd0, 4'd2, 32'h00100000, 5'b00000);
    send(26'h3FFFFFF, 10'd0, 0, 0, 3'd0, 3'd0, 4'd3, 32'h00800000, 5'b00011);
    send(ONE, 10'h3D8, 0, 0, 3'd0, 3'd3, 4'd4, 32'h00000001, 5'b00011);
`else
    send(ONE, 10'h3FE, 0, 0, 3'd0, 3'd0, 4'd2, 32'h00000000, 5'b00011);
    send(26'h3FFFFFF, 10'd0, 0, 0, 3'd0, 3'd0, 4'd3, 32'h00000000, 5'b00011);
    send(ONE, 10'h3D8, 1, 0, 3'd0, 3'd3, 4'd4, 32'h80000000, 5'b00011);
`endif
    send(ONE, 10'd127, 0, 0, 3'd3, 3'd0, 4'd5, 32'h7FC00000, 5'b10000);
    send(ONE, 10'd127, 1, 0, 3'd4, 3'd0, 4'd6, 32'hFF800000, 5'b01000);
    send(ONE, 10'd127, 1, 0, 3'd1, 3'd0, 4'd7, 32'h80000000, 5'b00000);
    send(ONE, 10'd127, 0, 0, 3'd2, 3'd0, 4'd8, 32'h7F800000, 5'b00000);
    drain();
    // back-to-back issue into a stalled consumer
    out_ready = 1'b0;
    fork
      begin : issue
        send(ONE, 10'd127, 0, 0, 3'd0, 3'd0, 4'd0, 32'h3F800000, 5'd0);
        send(ONE, 10'd128, 0, 0, 3'd0, 3'd0, 4'd1, 32'h40000000, 5'd0);
        send(ONE, 10'd129, 0, 0, 3'd0, 3'd0, 4'd2, 32'h40800000, 5'd0);
        send(ONE, 10'd130, 0, 0, 3'd0, 3'd0, 4'd3, 32'h41000000, 5'd0);
      end
      begin : ctl
        int n;
        n = 0;
        while (in_ready !== 1'b0 && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stall_ready_drop", {31'd0, in_ready}, 0);
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_low", {31'd0, in_ready}, 0);
          chk("stall_tag_hold", {28'd0, tag_o}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    // reset with operations in flight discards them
    out_ready = 1'b0;
    send(ONE, 10'd127, 0, 0, 3'd0, 3'd0, 4'd5, 32'h3F800000, 5'd0);
    send(ONE, 10'd127, 0, 0, 3'd0, 3'd0, 4'd6, 32'h3F800000, 5'd0);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_result", res, 0);
    chk("mid_rst_tag", {28'd0, tag_o}, 0);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_output", {31'd0, out_valid}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
